// File: rtl/test_status_pkg.sv
// rtl/test_status_pkg.sv - shared types and constants for the test status device
//
// Purpose: FSM state type, status encodings, watchdog fail code and the
// byte-to-index shift helper used by test_status_device and test_status_wdog.
// Ports: none (package).
// Optional feature macro: TEST_STATUS_WATCHDOG_EN (consumer of WDOG_CODE).

package test_status_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [31:0] STATUS_RUNNING = 32'h0;
  localparam logic [31:0] STATUS_PASS    = 32'h1;
  // Fail code 0x7FF encoded as (code << 1) | 1.
  localparam logic [31:0] WDOG_CODE      = 32'hFFF;

  // Number of low address bits that select a byte within one register.
  function automatic int log2_bytes(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/test_status_wdog.sv
// rtl/test_status_wdog.sv - inactivity watchdog for the test status device
//
// Purpose: counts cycles since the last accepted write and raises timeout
// while the count sits at WDOG_CYCLES-1. The count saturates there and
// freezes once every status register is nonzero.
// Only instantiated when TEST_STATUS_WATCHDOG_EN is defined.
// Ports:
//   clock      in  rising-edge clock
//   reset      in  asynchronous active-low reset
//   wr_accept  in  a write request was accepted this cycle
//   done       in  all status registers are nonzero
//   timeout    out load WDOG_CODE into still-zero registers this cycle

module test_status_wdog #(
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic wr_accept,
  input  logic done,
  output logic timeout
);

  localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_accept) begin
      count_d = '0;
    end else if (!done && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = !done && (count_q == LAST);

endmodule

// File: rtl/test_status_device.sv
// rtl/test_status_device.sv - memory-mapped writer of test completion status
//
// Purpose: NCONCURRENT sticky status registers written through a
// valid/ready request port with a one-entry response register. A register
// locks once nonzero; writes to it are dropped and flagged as errors.
// Optional macro: TEST_STATUS_WATCHDOG_EN adds an inactivity watchdog that
// fills still-zero registers with WDOG_CODE.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write/addr/wdata/wmask   request payload (byte address, byte enables)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata/rsp_error          response payload
//   status_regs                  flat register vector, register i at [i*DW +: DW]
//   done                         every status register is nonzero (registered)

module test_status_device
  import test_status_pkg::*;
#(
  parameter int NCONCURRENT = 1,
  parameter int REGBYTES    = 4,
  parameter int ADDR_W      = 12,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic [8*REGBYTES-1:0]           req_wdata,
  input  logic [REGBYTES-1:0]             req_wmask,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [8*REGBYTES-1:0]           rsp_rdata,
  output logic                            rsp_error,
  output logic [NCONCURRENT*8*REGBYTES-1:0] status_regs,
  output logic                            done
);

  localparam int DW  = 8 * REGBYTES;
  localparam int LSB = log2_bytes(REGBYTES);

  state_e                    state_q, state_d;
  logic [DW-1:0]             rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_error_q, rsp_error_d;
  logic [NCONCURRENT*DW-1:0] status_q, status_d;
  logic                      done_q, done_d;

  logic [ADDR_W-1:0] idx;
  logic              dec_err;
  logic              accept;
  logic [DW-1:0]     sel_val;
  logic              timeout;

  assign req_ready = (state_q == IDLE) || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr >> LSB;
  assign dec_err   = (idx >= ADDR_W'(NCONCURRENT));

`ifdef TEST_STATUS_WATCHDOG_EN
  test_status_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clock     (clock),
    .reset     (reset),
    .wr_accept (accept && req_write),
    .done      (done_q),
    .timeout   (timeout)
  );
`else
  // Without the watchdog the timeout never fires; WDOG_CYCLES has no role.
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES > 0);
  assign timeout         = 1'b0;
`endif

  // Current value of the addressed register (0 when out of range).
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NCONCURRENT; i++) begin
      if (idx == ADDR_W'(i)) sel_val = status_q[i*DW +: DW];
    end
  end

  always_comb begin
    status_d = status_q;
    for (int i = 0; i < NCONCURRENT; i++) begin
      if (accept && req_write && !dec_err && (idx == ADDR_W'(i))) begin
        // Only an unlocked (still zero) register takes the write.
        if (status_q[i*DW +: DW] == '0) begin
          for (int b = 0; b < REGBYTES; b++) begin
            if (req_wmask[b]) status_d[i*DW + b*8 +: 8] = req_wdata[b*8 +: 8];
          end
        end
      end else if (timeout && (status_q[i*DW +: DW] == '0)) begin
        // A same-cycle bus write to this register takes priority (branch above).
        status_d[i*DW +: DW] = DW'(WDOG_CODE);
      end
    end
  end

  always_comb begin
    done_d = 1'b1;
    for (int i = 0; i < NCONCURRENT; i++) begin
      if (status_q[i*DW +: DW] == DW'(STATUS_RUNNING)) done_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (accept) begin
      state_d     = RESP;
      rsp_error_d = dec_err || (req_write && (sel_val != '0));
      rsp_rdata_d = (!req_write && !dec_err) ? sel_val : '0;
    end else if (rsp_ready) begin
      state_d     = IDLE;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      status_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      status_q    <= status_d;
      done_q      <= done_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign status_regs = status_q;
  assign done        = done_q;

endmodule

// File: tb/tb_test_status_device.sv
// tb/tb_test_status_device.sv - directed self-checking bench for test_status_device
//
// Purpose: table of request vectors with hand-computed responses against a
// two-register device, plus hand-written backpressure, async reset and
// (with TEST_STATUS_WATCHDOG_EN) watchdog sequences.
// Ports: none (top-level bench).

module tb_test_status_device;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [63:0] status_regs;
  logic        done;

  int checks;
  int errors;

  test_status_device #(
    .NCONCURRENT (2),
    .REGBYTES    (4),
    .ADDR_W      (12),
    .WDOG_CYCLES (100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .status_regs (status_regs),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [63:0] e_status;
    logic        e_done;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = 1'b1;

    //            wr    addr     wdata          mask  rdata          err   status                  done
    vecs[0] = '{1'b1, 12'h000, 32'h0000_00AB, 4'h1, 32'h0,         1'b0, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_00AB, 1'b0, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[2] = '{1'b1, 12'h000, 32'h0000_0001, 4'hF, 32'h0,         1'b1, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[3] = '{1'b1, 12'h008, 32'h0000_0055, 4'hF, 32'h0,         1'b1, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[4] = '{1'b0, 12'h008, 32'h0,         4'h0, 32'h0,         1'b1, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[5] = '{1'b1, 12'h004, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 64'h0000_0000_0000_00AB, 1'b0};
    vecs[6] = '{1'b1, 12'h006, 32'h1234_5601, 4'h5, 32'h0,         1'b0, 64'h0034_0001_0000_00AB, 1'b1};
    vecs[7] = '{1'b0, 12'h005, 32'h0,         4'h0, 32'h0034_0001, 1'b0, 64'h0034_0001_0000_00AB, 1'b1};
    vecs[8] = '{1'b0, 12'hFFC, 32'h0,         4'h0, 32'h0,         1'b1, 64'h0034_0001_0000_00AB, 1'b1};

    // Reset state, both during reset and after release.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_status", status_regs, 64'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_rsp_valid", rsp_valid, 1'b0);
    chk("idle_rdata", rsp_rdata, 32'h0);
    chk("idle_err", rsp_error, 1'b0);
    chk("idle_done", done, 1'b0);

    // Table-driven single transactions with rsp_ready held high.
    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      drive(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wmask);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rsp_valid", v), rsp_valid, 1'b1);
      chk($sformatf("v%0d_rdata", v), rsp_rdata, vecs[v].e_rdata);
      chk($sformatf("v%0d_err", v), rsp_error, vecs[v].e_err);
      chk($sformatf("v%0d_status", v), status_regs, vecs[v].e_status);
      @(negedge clock);
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rsp_drain", v), rsp_valid, 1'b0);
      chk($sformatf("v%0d_done", v), done, vecs[v].e_done);
    end

    // Backpressure: response held 5 cycles, then back-to-back accept.
    @(negedge clock);
    drive(1'b0, 12'h000, 32'h0, 4'h0);
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("bp_first_valid", rsp_valid, 1'b1);
    @(negedge clock);
    drive(1'b0, 12'h004, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("bp%0d_valid", c), rsp_valid, 1'b1);
      chk($sformatf("bp%0d_rdata", c), rsp_rdata, 32'h0000_00AB);
      chk($sformatf("bp%0d_req_ready", c), req_ready, 1'b0);
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1'b1);
    @(posedge clock);
    #1;
    chk("b2b_valid", rsp_valid, 1'b1);
    chk("b2b_rdata", rsp_rdata, 32'h0034_0001);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("b2b_drain", rsp_valid, 1'b0);

    // Asynchronous reset while a response is pending.
    @(negedge clock);
    drive(1'b0, 12'h000, 32'h0, 4'h0);
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    chk("arst_pre_valid", rsp_valid, 1'b1);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 1'b0);
    chk("arst_status", status_regs, 64'h0);
    chk("arst_done", done, 1'b0);
    chk("arst_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;

`ifdef TEST_STATUS_WATCHDOG_EN
    // No writes: timeout lands on the 100th edge after release.
    repeat (99) @(posedge clock);
    #1;
    chk("wdog_before", status_regs, 64'h0);
    @(posedge clock);
    #1;
    chk("wdog_fire", status_regs, 64'h0000_0FFF_0000_0FFF);
    @(posedge clock);
    #1;
    chk("wdog_done", done, 1'b1);

    // A write on the timeout edge wins for its register.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (99) @(posedge clock);
    @(negedge clock);
    drive(1'b1, 12'h000, 32'h0000_0001, 4'hF);
    @(posedge clock);
    #1;
    chk("wdog_race", status_regs, 64'h0000_0FFF_0000_0001);
    chk("wdog_race_err", rsp_error, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
`else
    // Recovery after reset: a pass write to register 0 is accepted again.
    @(negedge clock);
    drive(1'b1, 12'h000, 32'h0000_0001, 4'hF);
    @(posedge clock);
    #1;
    chk("recover_status", status_regs, 64'h0000_0000_0000_0001);
    chk("recover_err", rsp_error, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("recover_done", done, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_status_device.md
# test_status_device

Memory-mapped writer side of the test-completion status interface. Software running on the core (or a harness agent) writes pass/fail codes into `NCONCURRENT` status registers through a simple valid/ready request/response port. The registers are presented as a flat vector to the bound test finisher, which decides when the simulation ends. The block sits on a peripheral port of the test harness, next to the harness RAM.

## Interface
Parameters:
- `NCONCURRENT`, 1, number of status registers (one per concurrent test thread)
- `REGBYTES`, 4, bytes per status register; power of two, 1..8
- `ADDR_W`, 12, request address width
- `WDOG_CYCLES`, 1000000, watchdog timeout in cycles (used only with the watchdog macro)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when both are high
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  `ADDR_W`  byte address
- `req_wdata`  in  `8*REGBYTES`  write data
- `req_wmask`  in  `REGBYTES`  byte enables
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumed when both are high
- `rsp_rdata`  out  `8*REGBYTES`  read data; 0 for writes and errors
- `rsp_error`  out  1  decode error or write to a locked register
- `status_regs`  out  `NCONCURRENT*8*REGBYTES`  register i occupies bits [i*8*REGBYTES +: 8*REGBYTES]
- `done`  out  1  every status register is nonzero

## Operation
- Register index is `req_addr >> log2(REGBYTES)`. Low address bits are ignored. An index of `NCONCURRENT` or more is a decode error: no write, `rsp_error`=1, `rsp_rdata`=0.
- Status encoding: 0 = running, 1 = pass, (code<<1)|1 = fail.
- Sticky lock: a register becomes locked once its value is nonzero. A write to a locked register is dropped and returns `rsp_error`=1. A write to an unlocked register applies per byte under `req_wmask`. An all-zero mask is legal and leaves the register unchanged.
- Reads return the current register value. A read in the same cycle as a write to the same register cannot occur, because the port handles one request per beat.
- Response path: a one-entry output register, with `req_ready = !rsp_valid || rsp_ready`.
  - The request is accepted on the edge where `req_valid && req_ready`.
  - The write is committed and the response is captured on that same edge.
  - `rsp_valid` and its payload then stay stable until `rsp_ready`.
- FSM states are IDLE (`rsp_valid`=0) and RESP (`rsp_valid`=1).
  - IDLE → RESP on accept.
  - RESP → IDLE on `rsp_ready` with no new accept.
  - RESP → RESP on `rsp_ready` with a simultaneous accept.
- `done` is registered and reflects the register contents after the write.

## Timing
- Reset values: `status_regs`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `done`=0, `req_ready`=1, watchdog counter=0.
- Latency: response appears 1 cycle after accept. `status_regs` updates 1 cycle after accept. `done` asserts 1 cycle after the `status_regs` update.
- Throughput: 1 request per cycle while `rsp_ready` is held high.
- Backpressure: when `rsp_valid && !rsp_ready`, `req_ready`=0 and no request is accepted.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and a pending response is discarded.

## Configuration
- `TEST_STATUS_WATCHDOG_EN` defined:
  - A cycle counter restarts at 0 on every accepted write and saturates.
  - When it reaches `WDOG_CYCLES-1`, every still-zero register is loaded with `WDOG_CODE` and locks.
  - If a bus write to a register and the timeout occur in the same cycle, the bus write wins for that register.
  - The counter stops once `done`=1.
- Macro undefined: no counter exists, and registers change only through bus writes. `WDOG_CYCLES` is ignored.

## Structure
- Package `test_status_pkg` holds:
  - the FSM enum `{IDLE, RESP}`
  - `STATUS_RUNNING`=0 and `STATUS_PASS`=1
  - `WDOG_CODE`='hFFF (fail code 0x7FF)
  - the helper function computing `log2(REGBYTES)`
- Sub-module `test_status_wdog` holds the counter and timeout pulse, and is instantiated only under `TEST_STATUS_WATCHDOG_EN`.

## Test plan
- Write 0x1 with mask 0xF to addr 0x0 (`NCONCURRENT`=1) → response next cycle with `rsp_error`=0; `status_regs`=0x1; `done`=1 one cycle later.
- Write 0x0000_00AB with mask 0x1 to addr 0x0, then read addr 0x0 → read returns 0xAB; then write 0x1 to addr 0x0 → `rsp_error`=1 and the register stays 0xAB.
- `NCONCURRENT`=2, write to addr 0x8 → `rsp_error`=1, `rsp_rdata`=0, both registers remain 0.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid` stays high with a stable payload and `req_ready`=0. Raise `rsp_ready` with `req_valid` high → back-to-back accept.
- Watchdog enabled, `WDOG_CYCLES`=100, no writes → at cycle 100 after reset release `status_regs`=0xFFF, then `done`=1. A write of 0x1 at cycle 99 yields 0x1.
- Assert reset while `rsp_valid`=1 → `rsp_valid`, `status_regs` and `done` drop to 0 without waiting for a clock edge.
